ac_sequencer: RTL and testbench
===============================

# ac_sequencer

Multicycle control FSM that sequences the accumulator (AC) datapath. It fetches 16-bit instructions over a request/acknowledge instruction port and decodes them. It drives the AC write enable, the AC source select (direct vs ALU) and the ALU opcode, and handles data-memory reads and writes over a second request/acknowledge port. It sits between program/data memory and the AC/ALU pair as the processor's control unit.

## Interface
- `PC_W`, default 12: program counter and operand address width.
- `DATA_W`, default 16: data, instruction and AC width.
- `clock` in 1: single system clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; leaves IDLE/HALT and begins fetching at the current `pc`.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out PC_W: fetch address (= `pc`).
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in DATA_W: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = write, 0 = read; valid while `dmem_req`.
- `dmem_addr` out PC_W: operand address.
- `dmem_wdata` out DATA_W: store data (= `ac_data`).
- `dmem_ack` in 1: access complete; read data valid this cycle.
- `dmem_rdata` in DATA_W: load data.
- `ac_data` in DATA_W: current AC output.
- `ac_write_en` out 1: AC load strobe.
- `ac_alu_out` out 1: AC source select; 1 = ALU result, 0 = `ac_data_in`.
- `ac_data_in` out DATA_W: direct AC load value.
- `alu_op` out 2: 0 pass, 1 add, 2 sub, 3 and.
- `alu_b` out DATA_W: ALU second operand (latched operand register).
- `pc` out PC_W: program counter.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky; set on an undefined opcode, cleared by reset or `start`.

## Operation
- Instruction format: opcode = [15:12], operand = [11:0] (address or zero-extended immediate).
- Opcodes:
  - 0 NOP.
  - 1 LDI: AC ← imm.
  - 2 LDM: AC ← mem.
  - 3 STM: mem ← AC.
  - 4 ADD: AC ← AC + mem.
  - 5 SUB: AC ← AC − mem.
  - 6 AND: AC ← AC & mem.
  - 7 JMP.
  - 8 JZ: jump if `ac_data` == 0.
  - F HALT.
  - 9–E: illegal; executes as NOP and sets `illegal`.
- States: IDLE, FETCH, DECODE, MEMRD, MEMWR, WB, HALT.
- IDLE → FETCH on `start`.
- FETCH: `imem_req`=1 until `imem_ack`. On ack, IR ← `imem_rdata`, `pc` ← `pc`+1 (wraps 0xFFF→0x000), go to DECODE.
- DECODE, by opcode:
  - LDI → WB.
  - LDM/ADD/SUB/AND → MEMRD.
  - STM → MEMWR.
  - JMP: `pc` ← operand, → FETCH.
  - JZ: taken → `pc` ← operand, → FETCH; not taken → FETCH.
  - NOP/illegal → FETCH.
  - HALT → HALT.
- MEMRD: `dmem_req`=1, `dmem_we`=0 until `dmem_ack`; operand reg ← `dmem_rdata`, → WB.
- MEMWR: `dmem_req`=1, `dmem_we`=1 until `dmem_ack`, → FETCH.
- WB: `ac_write_en`=1 for exactly one cycle, → FETCH.
  - LDI: `ac_alu_out`=0, `ac_data_in`=imm.
  - LDM: `ac_alu_out`=1, `alu_op`=pass on `alu_b`.
  - ADD/SUB/AND: `ac_alu_out`=1, `alu_op` per opcode, `alu_b`=operand reg.
- HALT: `halted`=1, no requests. `start` → FETCH at the current `pc`.
- `start` outside IDLE/HALT is ignored.
- Overflow is the ALU's concern; the sequencer does not observe it.

## Timing
- Reset values, all outputs: `pc`=0, `halted`=0, `illegal`=0, all req/we/strobe outputs 0, `ac_data_in`=0, `alu_b`=0, `alu_op`=0, `ac_alu_out`=0; state IDLE.
- All outputs are registered or decoded from the state register only; no combinational path from `imem_ack`/`dmem_ack` to outputs.
- Request hold:
  - `imem_addr`, `dmem_addr`, `dmem_we` and `dmem_wdata` hold stable while the corresponding req is high.
  - Req drops the cycle after ack.
  - Zero-wait ack (ack in the same cycle req first rises) is legal.
- Minimum latency with zero-wait memory:
  - NOP/JMP/JZ: 2 cycles (FETCH, DECODE).
  - LDI: 3 cycles.
  - STM: 3 cycles.
  - LDM/ALU: 4 cycles.
- JZ samples `ac_data` in DECODE. A preceding WB has already updated AC, so there is no hazard.
- `reset_n` low mid-access drops req on the next edge. No partial AC write occurs.

## Structure
- Shared package `ac_pkg`: opcode constants, `alu_op` encodings, state enum, `DATA_W`/`PC_W` defaults.
- Sub-module `ac_decoder` (combinational): opcode → {next-state class, `alu_op`, `ac_alu_out`, illegal}.

## Test plan
- Reset, then `start`; program LDI 0x00A, HALT at 0/1 → one `ac_write_en` pulse, `ac_alu_out`=0, `ac_data_in`=10; `halted`=1; `pc`=2.
- LDM 0x010 (mem=15), ADD 0x011 (mem=5), STM 0x012 → `alu_op` pass then add. Write to 0x012 carries `dmem_wdata`=20, `dmem_we`=1.
- JZ 0x020 with AC=0 → next `imem_addr`=0x020. With AC=3 → sequential `pc`.
- `imem_ack`/`dmem_ack` delayed 3 cycles → req and address held stable 4 cycles, no duplicate access, no extra `ac_write_en`.
- Opcode 0xA → `illegal`=1, AC not written, fetch continues. `start` after a later HALT clears it.
- `pc`=0xFFF with NOP → next fetch at 0x000. `reset_n` low during MEMRD → IDLE, `pc`=0, `dmem_req`=0 next cycle.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator-machine control unit: widths,
// opcode and ALU encodings, FSM states and the decoder result record.
package ac_pkg;

  localparam int unsigned AC_DATA_W = 16;
  localparam int unsigned AC_PC_W   = 12;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned OPND_W    = 12;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDM  = 4'h2;
  localparam logic [OPC_W-1:0] OP_STM  = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h4;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h5;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h8;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_AND  = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_MEMWR,
    S_WB,
    S_HALT
  } state_e;

  // Where DECODE sends the machine next; jumps resolve to FETCH.
  typedef enum logic [2:0] {
    CLS_NEXT,
    CLS_WB,
    CLS_MEMRD,
    CLS_MEMWR,
    CLS_JMP,
    CLS_JZ,
    CLS_HALT
  } exec_cls_e;

  typedef struct packed {
    exec_cls_e cls;
    alu_op_e   alu_op;
    logic      alu_sel;
    logic      illegal;
  } dec_t;

endpackage

// File: rtl/ac_decoder.sv
// Combinational opcode decoder: execution class, ALU operation, AC source
// select and the illegal-opcode flag.
module ac_decoder
  import ac_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);

  always_comb begin
    dec = '{cls: CLS_NEXT, alu_op: ALU_PASS, alu_sel: 1'b0, illegal: 1'b0};
    case (opcode)
      OP_NOP:  ;
      OP_LDI:  dec.cls = CLS_WB;
      OP_LDM:  begin
        dec.cls     = CLS_MEMRD;
        dec.alu_sel = 1'b1;
      end
      OP_STM:  dec.cls = CLS_MEMWR;
      OP_ADD:  begin
        dec.cls     = CLS_MEMRD;
        dec.alu_sel = 1'b1;
        dec.alu_op  = ALU_ADD;
      end
      OP_SUB:  begin
        dec.cls     = CLS_MEMRD;
        dec.alu_sel = 1'b1;
        dec.alu_op  = ALU_SUB;
      end
      OP_AND:  begin
        dec.cls     = CLS_MEMRD;
        dec.alu_sel = 1'b1;
        dec.alu_op  = ALU_AND;
      end
      OP_JMP:  dec.cls = CLS_JMP;
      OP_JZ:   dec.cls = CLS_JZ;
      OP_HALT: dec.cls = CLS_HALT;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ac_sequencer.sv
// Multicycle control unit for the accumulator datapath: fetches, decodes and
// sequences AC/ALU writes and data-memory accesses over req/ack ports.
module ac_sequencer
  import ac_pkg::*;
#(
  parameter int unsigned PC_W   = AC_PC_W,
  parameter int unsigned DATA_W = AC_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [DATA_W-1:0] ac_data,
  output logic              ac_write_en,
  output logic              ac_alu_out,
  output logic [DATA_W-1:0] ac_data_in,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_b,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal
);

  state_e             state, state_nxt;
  logic [DATA_W-1:0]  ir;
  logic [DATA_W-1:0]  opnd;
  logic [OPC_W-1:0]   opcode;
  logic [OPND_W-1:0]  operand;
  logic               run_start;
  logic               jump_taken;
  dec_t               dec;

  assign opcode  = ir[DATA_W-1 -: OPC_W];
  assign operand = ir[OPND_W-1:0];

  ac_decoder u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  assign run_start  = start && ((state == S_IDLE) || (state == S_HALT));
  assign jump_taken = (state == S_DECODE) &&
                      ((dec.cls == CLS_JMP) || ((dec.cls == CLS_JZ) && (ac_data == '0)));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          CLS_WB:    state_nxt = S_WB;
          CLS_MEMRD: state_nxt = S_MEMRD;
          CLS_MEMWR: state_nxt = S_MEMWR;
          CLS_HALT:  state_nxt = S_HALT;
          default:   state_nxt = S_FETCH;
        endcase
      end
      S_MEMRD:        if (dmem_ack) state_nxt = S_WB;
      S_MEMWR:        if (dmem_ack) state_nxt = S_FETCH;
      S_WB:           state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Instruction, operand, PC and sticky illegal flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ir      <= '0;
      opnd    <= '0;
      pc      <= '0;
      illegal <= 1'b0;
    end else begin
      if (run_start) illegal <= 1'b0;
      if ((state == S_FETCH) && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + PC_W'(1);
      end
      if ((state == S_DECODE) && dec.illegal) illegal <= 1'b1;
      if (jump_taken) pc <= PC_W'(operand);
      if ((state == S_MEMRD) && dmem_ack) opnd <= dmem_rdata;
    end
  end

  // Addresses and data come straight from registers so they stay put for
  // the whole request; the strobes are decoded from the state alone.
  assign imem_addr  = pc;
  assign dmem_addr  = PC_W'(operand);
  assign dmem_wdata = ac_data;
  assign ac_data_in = DATA_W'(operand);
  assign alu_b      = opnd;

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ac_write_en = 1'b0;
    ac_alu_out  = 1'b0;
    alu_op      = ALU_PASS;
    halted      = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_MEMRD: dmem_req = 1'b1;
      S_MEMWR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
      end
      S_WB: begin
        ac_write_en = 1'b1;
        ac_alu_out  = dec.alu_sel;
        alu_op      = dec.alu_op;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ac_sequencer.sv
// Bench for ac_sequencer: memory/AC environment, directed program table,
// multi-cycle corner sequences and random programs against an ISA model.
module tb_ac_sequencer;

  localparam int unsigned PC_W   = 12;
  localparam int unsigned DATA_W = 16;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [PC_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] ac_data;
  logic              ac_write_en;
  logic              ac_alu_out;
  logic [DATA_W-1:0] ac_data_in;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic              illegal;

  ac_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ac_data(ac_data),
    .ac_write_en(ac_write_en), .ac_alu_out(ac_alu_out), .ac_data_in(ac_data_in),
    .alu_op(alu_op), .alu_b(alu_b), .pc(pc), .halted(halted), .illegal(illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef logic [31:0] q32_t[$];

  int errors = 0;
  int checks = 0;

  logic [15:0] imem [4096];
  logic [15:0] dmem [4096];
  logic [15:0] m_imem [4096];
  logic [15:0] m_dmem [4096];

  q32_t obs_fetch, obs_acw, obs_memw, obs_aluop;
  q32_t exp_fetch, exp_acw, exp_memw, exp_aluop;
  logic [11:0] exp_pc;
  logic        exp_ill;

  int i_dly_cfg = 0;
  int d_dly_cfg = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic cmp_q(input string name, input q32_t act, input q32_t want);
    chk({name, "_len"}, 32'(act.size()), 32'(want.size()));
    for (int i = 0; i < act.size() && i < want.size(); i++) begin
      if (act[i] !== want[i]) begin
        chk($sformatf("%s[%0d]", name, i), act[i], want[i]);
        break;
      end
    end
  endtask

  // Environment: memories with programmable ack delay, and the AC register
  // driven by the sequencer's strobes. Also watches request hold/drop rules.
  initial begin : env
    bit i_act, d_act, i_drop, d_drop, prev_we;
    int i_cnt, d_cnt, i_dly, d_dly;
    logic [PC_W-1:0]   i_addr, d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0; ac_data = '0;
    i_act = 0; d_act = 0; i_drop = 0; d_drop = 0; prev_we = 0;
    i_cnt = 0; d_cnt = 0; i_dly = 0; d_dly = 0;
    i_addr = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ac_data = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
        i_act = 0; d_act = 0; i_drop = 0; d_drop = 0; prev_we = 0;
      end else begin
        if (ac_write_en) begin
          chk("ac_we_single", 32'(prev_we), 32'd0);
          obs_aluop.push_back(32'(alu_op));
          if (ac_alu_out) begin
            case (alu_op)
              2'd0: ac_data = alu_b;
              2'd1: ac_data = ac_data + alu_b;
              2'd2: ac_data = ac_data - alu_b;
              default: ac_data = ac_data & alu_b;
            endcase
          end else begin
            ac_data = ac_data_in;
          end
          obs_acw.push_back(32'(ac_data));
        end
        prev_we = ac_write_en;

        if (i_drop) begin
          chk("imem_req_drop", 32'(imem_req), 32'd0);
          i_drop = 0;
        end
        imem_ack = 1'b0;
        if (imem_req) begin
          if (!i_act) begin
            i_act = 1; i_addr = imem_addr; i_cnt = 0;
            i_dly = (i_dly_cfg < 0) ? int'($urandom_range(0, 3)) : i_dly_cfg;
          end else begin
            chk("imem_addr_hold", 32'(imem_addr), 32'(i_addr));
          end
          if (i_cnt == i_dly) begin
            imem_ack = 1'b1;
            imem_rdata = imem[imem_addr];
            obs_fetch.push_back(32'(imem_addr));
            i_act = 0; i_drop = 1;
          end else begin
            i_cnt++;
          end
        end else begin
          i_act = 0;
        end

        if (d_drop) begin
          chk("dmem_req_drop", 32'(dmem_req), 32'd0);
          d_drop = 0;
        end
        dmem_ack = 1'b0;
        if (dmem_req) begin
          if (!d_act) begin
            d_act = 1; d_addr = dmem_addr; d_we = dmem_we; d_wdata = dmem_wdata; d_cnt = 0;
            d_dly = (d_dly_cfg < 0) ? int'($urandom_range(0, 3)) : d_dly_cfg;
          end else begin
            chk("dmem_addr_hold", 32'(dmem_addr), 32'(d_addr));
            chk("dmem_we_hold", 32'(dmem_we), 32'(d_we));
            if (d_we) chk("dmem_wdata_hold", 32'(dmem_wdata), 32'(d_wdata));
          end
          if (d_cnt == d_dly) begin
            dmem_ack = 1'b1;
            if (dmem_we) begin
              dmem[dmem_addr] = dmem_wdata;
              obs_memw.push_back({4'h0, dmem_addr, dmem_wdata});
            end else begin
              dmem_rdata = dmem[dmem_addr];
            end
            d_act = 0; d_drop = 1;
          end else begin
            d_cnt++;
          end
        end else begin
          d_act = 0;
        end
      end
    end
  end

  // ISA-level reference: runs the program in m_imem/m_dmem from pc 0, AC 0.
  task automatic model_run();
    logic [11:0] mpc, opd;
    logic [15:0] ac, ir, mv;
    logic [3:0]  op;
    bit done, wr;
    exp_fetch.delete(); exp_acw.delete(); exp_memw.delete();
    exp_ill = 1'b0; mpc = '0; ac = '0; done = 0;
    for (int s = 0; s < 500 && !done; s++) begin
      exp_fetch.push_back(32'(mpc));
      ir = m_imem[mpc];
      mpc = mpc + 12'd1;
      op = ir[15:12]; opd = ir[11:0]; mv = m_dmem[opd]; wr = 0;
      case (op)
        4'h0: ;
        4'h1: begin ac = 16'(opd); wr = 1; end
        4'h2: begin ac = mv; wr = 1; end
        4'h3: begin m_dmem[opd] = ac; exp_memw.push_back({4'h0, opd, ac}); end
        4'h4: begin ac = ac + mv; wr = 1; end
        4'h5: begin ac = ac - mv; wr = 1; end
        4'h6: begin ac = ac & mv; wr = 1; end
        4'h7: mpc = opd;
        4'h8: if (ac == 16'd0) mpc = opd;
        4'hF: done = 1;
        default: exp_ill = 1'b1;
      endcase
      if (wr) exp_acw.push_back(32'(ac));
    end
    exp_pc = mpc;
  endtask

  task automatic load_default();
    for (int a = 0; a < 4096; a++) begin
      imem[a] = 16'hF000;
      dmem[a] = 16'h0000;
    end
  endtask

  task automatic clear_obs();
    obs_fetch.delete(); obs_acw.delete(); obs_memw.delete(); obs_aluop.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // n counts negedges from the one after start is sampled until halted.
  task automatic run_prog(input int budget, output int n);
    pulse_start();
    n = 1;
    while (!halted && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  typedef struct {
    logic [15:0] i0, i1, mval;
    logic [15:0] exp_ac, exp_mem;
    logic [11:0] exp_pc;
    logic        exp_ill;
    int          exp_n;
    int          exp_wr;
  } vec_t;

  vec_t tbl[12];

  initial begin : main
    int n;
    reset_n = 1'b0;
    start   = 1'b0;

    tbl[0]  = '{16'h100A, 16'hF000, 16'h0000, 16'h000A, 16'h0000, 12'h002, 1'b0,  6, 1};
    tbl[1]  = '{16'h1007, 16'h4010, 16'h0005, 16'h000C, 16'h0005, 12'h003, 1'b0, 10, 2};
    tbl[2]  = '{16'h1007, 16'h5010, 16'h0009, 16'hFFFE, 16'h0009, 12'h003, 1'b0, 10, 2};
    tbl[3]  = '{16'h100C, 16'h6010, 16'h000A, 16'h0008, 16'h000A, 12'h003, 1'b0, 10, 2};
    tbl[4]  = '{16'h1001, 16'h2010, 16'hBEEF, 16'hBEEF, 16'hBEEF, 12'h003, 1'b0, 10, 2};
    tbl[5]  = '{16'h1000, 16'h8020, 16'h0000, 16'h0000, 16'h0000, 12'h021, 1'b0,  8, 1};
    tbl[6]  = '{16'h1003, 16'h8020, 16'h0000, 16'h0003, 16'h0000, 12'h003, 1'b0,  8, 1};
    tbl[7]  = '{16'h7030, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'h031, 1'b0,  5, 0};
    tbl[8]  = '{16'hA123, 16'h1005, 16'h0000, 16'h0005, 16'h0000, 12'h003, 1'b1,  8, 1};
    tbl[9]  = '{16'h1055, 16'h3010, 16'h0000, 16'h0055, 16'h0055, 12'h003, 1'b0,  9, 1};
    tbl[10] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'h003, 1'b0,  7, 0};
    tbl[11] = '{16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'h001, 1'b0,  3, 0};

    load_default();
    repeat (3) @(negedge clock);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_ac_we", 32'(ac_write_en), 32'd0);
    chk("rst_ac_alu_out", 32'(ac_alu_out), 32'd0);
    chk("rst_ac_data_in", 32'(ac_data_in), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    reset_n = 1'b1;

    // Directed single-instruction programs, zero-wait memory.
    for (int k = 0; k < 12; k++) begin
      do_reset();
      load_default();
      imem[0] = tbl[k].i0;
      imem[1] = tbl[k].i1;
      dmem[12'h010] = tbl[k].mval;
      clear_obs();
      run_prog(200, n);
      chk($sformatf("t%0d_ac", k), 32'(ac_data), 32'(tbl[k].exp_ac));
      chk($sformatf("t%0d_mem", k), 32'(dmem[12'h010]), 32'(tbl[k].exp_mem));
      chk($sformatf("t%0d_pc", k), 32'(pc), 32'(tbl[k].exp_pc));
      chk($sformatf("t%0d_illegal", k), 32'(illegal), 32'(tbl[k].exp_ill));
      chk($sformatf("t%0d_cycles", k), n, tbl[k].exp_n);
      chk($sformatf("t%0d_ac_writes", k), 32'(obs_acw.size()), 32'(tbl[k].exp_wr));
    end

    // Illegal flag: set by 0xA, cleared by the next start out of HALT.
    do_reset();
    load_default();
    imem[0] = 16'hA000;
    clear_obs();
    run_prog(100, n);
    chk("ill_set", 32'(illegal), 32'd1);
    chk("ill_no_ac_write", 32'(obs_acw.size()), 32'd0);
    run_prog(100, n);
    chk("ill_cleared", 32'(illegal), 32'd0);
    chk("ill_restart_pc", 32'(pc), 32'd3);
    chk("ill_restart_cycles", n, 3);

    // Three-cycle ack delay on both ports.
    do_reset();
    load_default();
    imem[0] = 16'h2010; imem[1] = 16'h4011; imem[2] = 16'h3012;
    dmem[12'h010] = 16'd15; dmem[12'h011] = 16'd5;
    i_dly_cfg = 3; d_dly_cfg = 3;
    clear_obs();
    run_prog(200, n);
    exp_fetch = {32'h0, 32'h1, 32'h2, 32'h3};
    exp_acw   = {32'd15, 32'd20};
    exp_aluop = {32'd0, 32'd1};
    exp_memw  = {32'h0012_0014};
    cmp_q("dly_fetch", obs_fetch, exp_fetch);
    cmp_q("dly_acw", obs_acw, exp_acw);
    cmp_q("dly_aluop", obs_aluop, exp_aluop);
    cmp_q("dly_memw", obs_memw, exp_memw);
    chk("dly_mem12", 32'(dmem[12'h012]), 32'd20);
    chk("dly_cycles", n, 35);
    i_dly_cfg = 0; d_dly_cfg = 0;

    // PC wrap: JZ to 0xFFF, NOP there, next fetch at 0x000.
    do_reset();
    load_default();
    imem[0] = 16'h8FFF;
    imem[12'hFFF] = 16'h0000;
    clear_obs();
    pulse_start();
    n = 0;
    while (obs_fetch.size() < 3 && n < 100) begin
      @(negedge clock);
      n++;
    end
    exp_fetch = {32'h000, 32'hFFF, 32'h000};
    obs_fetch = obs_fetch[0:2];
    cmp_q("wrap_fetch", obs_fetch, exp_fetch);

    // Reset in the middle of a data read.
    do_reset();
    load_default();
    imem[0] = 16'h2010;
    d_dly_cfg = 10;
    clear_obs();
    pulse_start();
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("memrd_reached", 32'(dmem_req), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rstmid_dmem_req", 32'(dmem_req), 32'd0);
    chk("rstmid_pc", 32'(pc), 32'd0);
    chk("rstmid_ac_writes", 32'(obs_acw.size()), 32'd0);
    reset_n = 1'b1;
    d_dly_cfg = 0;

    // Random forward-branching programs with random ack delays.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      load_default();
      for (int a = 0; a < 24; a++) begin
        logic [3:0]  op;
        logic [11:0] opd;
        op = 4'($urandom_range(0, 15));
        case (op)
          4'h2, 4'h3, 4'h4, 4'h5, 4'h6: opd = 12'h100 + 12'($urandom_range(0, 15));
          4'h7, 4'h8: opd = 12'(a + 1 + int'($urandom_range(0, 8)));
          default: opd = 12'($urandom);
        endcase
        imem[a] = {op, opd};
      end
      for (int a = 12'h100; a < 12'h110; a++) dmem[a] = 16'($urandom);
      m_imem = imem;
      m_dmem = dmem;
      model_run();
      i_dly_cfg = -1; d_dly_cfg = -1;
      clear_obs();
      run_prog(2000, n);
      cmp_q($sformatf("r%0d_fetch", r), obs_fetch, exp_fetch);
      cmp_q($sformatf("r%0d_acw", r), obs_acw, exp_acw);
      cmp_q($sformatf("r%0d_memw", r), obs_memw, exp_memw);
      chk($sformatf("r%0d_pc", r), 32'(pc), 32'(exp_pc));
      chk($sformatf("r%0d_illegal", r), 32'(illegal), 32'(exp_ill));
    end
    i_dly_cfg = 0; d_dly_cfg = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
